ycr1_pipe_mprf_mp: RTL and testbench
====================================

Name: ycr1_pipe_mprf_mp

Overview:
- Parametrised multi-port register file for the ycr1 pipeline: N read ports, M write ports, configurable depth and width, selectable read latency.
- Register x0 is hardwired to zero.
- Integrated per-register pending scoreboard so EXU/LSU can track in-flight destination writes.
- Intended drop-in for dual-issue / long-latency writeback variants of the core; sits between EXU decode/writeback and the register array.

Parameters:
XLEN, 32, data width in bits
DEPTH, 32, number of registers (power of 2; 16 for RVE); entry 0 reads as zero
AW, $clog2(DEPTH), address width
NRD, 2, number of read ports
NWR, 1, number of write ports (1..4)
RD_STAGE, 1, 0 = combinational read, 1 = registered write-first read
RET_IDX, 10, register index mirrored on func_return_val_o

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_addr_i  in  NRD*AW  read addresses, port k at [k*AW +: AW]
rd_data_o  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
rd_busy_o  out  NRD  scoreboard pending bit of addressed register, per port
wr_req_i  in  NWR  write request per port
wr_addr_i  in  NWR*AW  write addresses
wr_data_i  in  NWR*XLEN  write data
rsv_req_i  in  1  reserve (mark pending) request
rsv_addr_i  in  AW  register to mark pending
flush_i  in  1  clear all pending bits
func_return_val_o  out  XLEN  contents of register RET_IDX (debug)

Behaviour:
- Reset (rst_n low, async): all entries 1..DEPTH-1 = 0, all pending bits = 0, read-stage registers = 0. rd_data_o = 0, rd_busy_o = 0, func_return_val_o = 0.
- Write: on posedge, for each port j with wr_req_i[j] and wr_addr_i[j] != 0, the entry is updated. Writes to address 0 are ignored.
- Write collision (two ports, same address, same cycle): highest port index wins.
- Pending bit set: on posedge when rsv_req_i and rsv_addr_i != 0.
- Pending bit clear: on posedge when any valid write targets that register.
- Reserve and write to the same register in the same cycle: the reserve wins, bit ends set (newer instruction pending).
- flush_i: clears all pending bits; priority over reserve and write-clear in the same cycle. Array writes still occur.
- Register 0 pending bit is constant 0.
- RD_STAGE=0:
  - rd_data_o[k] = array[rd_addr_i[k]], or 0 if address 0; combinational, read-before-write (same-cycle write not visible).
  - rd_busy_o[k] = current pending bit, combinational.
- RD_STAGE=1:
  - Address sampled at edge n; rd_data_o valid after edge n and held until next edge (1-cycle latency).
  - Write-first: a same-cycle write to the sampled address at edge n is bypassed (winning port's data), with the same collision priority.
  - Address 0 returns 0.
  - rd_busy_o[k] = pending-bit next-state of the sampled address, including reserve/clear/flush of cycle n.
- Read ports are fully independent; any number may address the same register.
- func_return_val_o is combinational from array[RET_IDX]; it is not affected by RD_STAGE.
- Unknown address/data on a valid write is flagged by a simulation-only assertion under YCR1_TRGT_SIMULATION, disabled during reset.

Optional Feature:
- Macro: YCR1_MPRF_PARITY_EN.
- When defined:
  - Each entry stores an extra even-parity bit computed from the winning write data.
  - Extra output rd_perr_o [NRD] flags a parity mismatch on the read data, with the same latency as rd_data_o.
  - The bypass path always reports no error; address 0 reports no error.
  - Parity bits reset to 0, which is consistent with zero data.
  - Extra input perr_inj_i [1], sim/DFT only: inverts the stored parity on the next write.
- When undefined: no parity storage, rd_perr_o and perr_inj_i are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then read all addresses on all ports -> rd_data_o = 0, rd_busy_o = 0, func_return_val_o = 0.
- RD_STAGE=1, write x5 = 0xDEADBEEF while port0 reads x5 in the same cycle -> port0 = 0xDEADBEEF next cycle. RD_STAGE=0 same stimulus -> old value 0 that cycle, 0xDEADBEEF the following cycle.
- NWR=2, both ports write x7 (port0 0x11111111, port1 0x22222222) -> x7 = 0x22222222; a concurrent RD_STAGE=1 bypass also returns 0x22222222.
- Write x0 = 0xFFFFFFFF, reserve x0 -> reads of x0 return 0, rd_busy_o = 0.
- Scoreboard:
  - Reserve x3 -> busy = 1.
  - Write x3 -> busy = 0.
  - Reserve x4 and write x4 in the same cycle -> busy = 1.
  - Reserve x6 with flush_i in the same cycle -> busy = 0.
- Write x10 = 0x00000042 -> func_return_val_o = 0x42 after the edge. Assert rst_n mid-sequence (between edges) -> all outputs go to 0 immediately.

Source files
------------

// File: rtl/ycr1_pipe_mprf_mp.sv
// rtl/ycr1_pipe_mprf_mp.sv - multi-port register file with pending-write scoreboard
// Optional parity protection: define YCR1_MPRF_PARITY_EN.
module ycr1_pipe_mprf_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int RD_STAGE = 1,
    parameter int RET_IDX  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD*XLEN-1:0]  rd_data_o,
    output logic [NRD-1:0]       rd_busy_o,
    input  logic [NWR-1:0]       wr_req_i,
    input  logic [NWR*AW-1:0]    wr_addr_i,
    input  logic [NWR*XLEN-1:0]  wr_data_i,
    input  logic                 rsv_req_i,
    input  logic [AW-1:0]        rsv_addr_i,
    input  logic                 flush_i,
`ifdef YCR1_MPRF_PARITY_EN
    input  logic                 perr_inj_i,
    output logic [NRD-1:0]       rd_perr_o,
`endif
    output logic [XLEN-1:0]      func_return_val_o
);

    logic [XLEN-1:0]  regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_next;
    logic [NWR-1:0]   wr_vld;
`ifdef YCR1_MPRF_PARITY_EN
    logic [DEPTH-1:0] par;
`endif

    always_comb begin
        wr_vld = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_vld[j] = wr_req_i[j] && (wr_addr_i[j*AW +: AW] != '0);
        end
    end

    // Ascending port order: the highest-indexed colliding port lands last and wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
`ifdef YCR1_MPRF_PARITY_EN
            par <= '0;
`endif
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_vld[j]) begin
                    regs[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
`ifdef YCR1_MPRF_PARITY_EN
                    par[wr_addr_i[j*AW +: AW]]  <= (^wr_data_i[j*XLEN +: XLEN]) ^ perr_inj_i;
`endif
                end
            end
        end
    end

    // Priority low to high: write-clear, reserve, flush.
    always_comb begin
        pend_next = pend;
        for (int j = 0; j < NWR; j++) begin
            if (wr_vld[j]) begin
                pend_next[wr_addr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_req_i) begin
            pend_next[rsv_addr_i] = 1'b1;
        end
        if (flush_i) begin
            pend_next = '0;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    assign func_return_val_o = regs[RET_IDX];

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] arr_data;
        logic            arr_perr;

        assign ra       = rd_addr_i[k*AW +: AW];
        assign arr_data = (ra == '0) ? '0 : regs[ra];
`ifdef YCR1_MPRF_PARITY_EN
        assign arr_perr = (ra != '0) && ((^regs[ra]) != par[ra]);
`else
        assign arr_perr = 1'b0;
`endif

        if (RD_STAGE == 0) begin : g_comb
            assign rd_data_o[k*XLEN +: XLEN] = arr_data;
            assign rd_busy_o[k]              = pend[ra];
`ifdef YCR1_MPRF_PARITY_EN
            assign rd_perr_o[k]              = arr_perr;
`endif
        end else begin : g_reg
            logic            byp_hit;
            logic [XLEN-1:0] byp_data;
            logic [XLEN-1:0] data_q;
            logic            busy_q;
            logic            perr_q;

            always_comb begin
                byp_hit  = 1'b0;
                byp_data = '0;
                for (int j = 0; j < NWR; j++) begin
                    if (wr_vld[j] && (wr_addr_i[j*AW +: AW] == ra)) begin
                        byp_hit  = 1'b1;
                        byp_data = wr_data_i[j*XLEN +: XLEN];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                    busy_q <= 1'b0;
                    perr_q <= 1'b0;
                end else begin
                    data_q <= byp_hit ? byp_data : arr_data;
                    busy_q <= pend_next[ra];
                    perr_q <= byp_hit ? 1'b0 : arr_perr;
                end
            end

            assign rd_data_o[k*XLEN +: XLEN] = data_q;
            assign rd_busy_o[k]              = busy_q;
`ifdef YCR1_MPRF_PARITY_EN
            assign rd_perr_o[k]              = perr_q;
`else
            logic unused_perr;
            assign unused_perr = perr_q;
`endif
        end
    end

`ifdef YCR1_TRGT_SIMULATION
    for (genvar j = 0; j < NWR; j++) begin : g_wr_chk
        a_wr_known : assert property (@(posedge clk) disable iff (!rst_n)
            wr_req_i[j] |-> !$isunknown({wr_addr_i[j*AW +: AW], wr_data_i[j*XLEN +: XLEN]}));
    end
`endif

endmodule

// File: tb/tb_ycr1_pipe_mprf_mp.sv
// tb/tb_ycr1_pipe_mprf_mp.sv - scoreboard bench for both read-stage variants of the register file
module tb_ycr1_pipe_mprf_mp;
    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR-1:0]      wr_req;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_req;
    logic [AW-1:0]       rsv_addr;
    logic                flush;
    logic [NRD*XLEN-1:0] rdata_c, rdata_r;
    logic [NRD-1:0]      busy_c, busy_r;
    logic [XLEN-1:0]     ret_c, ret_r;
`ifdef YCR1_MPRF_PARITY_EN
    logic                perr_inj = 1'b0;
    logic [NRD-1:0]      perr_c, perr_r;
`endif

    logic [XLEN-1:0]  m_regs [DEPTH];
    logic [DEPTH-1:0] m_pend;
    logic [31:0]      q_c [$];
    logic [31:0]      q_r [$];
    int               n_chk = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    ycr1_pipe_mprf_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .RD_STAGE(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rdata_r), .rd_busy_o(busy_r),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_req_i(rsv_req), .rsv_addr_i(rsv_addr), .flush_i(flush),
`ifdef YCR1_MPRF_PARITY_EN
        .perr_inj_i(perr_inj), .rd_perr_o(perr_r),
`endif
        .func_return_val_o(ret_r));

    ycr1_pipe_mprf_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .RD_STAGE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rdata_c), .rd_busy_o(busy_c),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_req_i(rsv_req), .rsv_addr_i(rsv_addr), .flush_i(flush),
`ifdef YCR1_MPRF_PARITY_EN
        .perr_inj_i(perr_inj), .rd_perr_o(perr_c),
`endif
        .func_return_val_o(ret_c));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pop_c();
        if (q_c.size() == 0) return 'x;
        return q_c.pop_front();
    endfunction

    function automatic logic [31:0] pop_r();
        if (q_r.size() == 0) return 'x;
        return q_r.pop_front();
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
        m_pend = '0;
    endtask

    task automatic set_idle();
        wr_req   = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_req  = 1'b0;
        rsv_addr = '0;
        flush    = 1'b0;
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic run_cycle();
        logic [AW-1:0] a;
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr[k*AW +: AW];
            q_c.push_back((a == 0) ? 32'h0 : m_regs[a]);
            q_c.push_back({31'b0, m_pend[a]});
        end
        for (int j = 0; j < NWR; j++) begin
            a = wr_addr[j*AW +: AW];
            if (wr_req[j] && a != 0) begin
                m_regs[a] = wr_data[j*XLEN +: XLEN];
                m_pend[a] = 1'b0;
            end
        end
        if (rsv_req && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        if (flush) m_pend = '0;
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr[k*AW +: AW];
            q_r.push_back((a == 0) ? 32'h0 : m_regs[a]);
            q_r.push_back({31'b0, m_pend[a]});
        end
        #1;
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("c_data%0d", k), rdata_c[k*XLEN +: XLEN], pop_c());
            check($sformatf("c_busy%0d", k), {31'b0, busy_c[k]}, pop_c());
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("r_data%0d", k), rdata_r[k*XLEN +: XLEN], pop_r());
            check($sformatf("r_busy%0d", k), {31'b0, busy_r[k]}, pop_r());
        end
        check("r_ret", ret_r, m_regs[10]);
        check("c_ret", ret_c, m_regs[10]);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata_r"}, rdata_r[31:0] | rdata_r[63:32], 32'h0);
        check({tag, "_rdata_c"}, rdata_c[31:0] | rdata_c[63:32], 32'h0);
        check({tag, "_busy"}, {28'b0, busy_r, busy_c}, 32'h0);
        check({tag, "_ret_r"}, ret_r, 32'h0);
        check({tag, "_ret_c"}, ret_c, 32'h0);
    endtask

    initial begin
        set_idle();
        rd_addr = {5'd10, 5'd3};
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            run_cycle();
        end

        // Same-cycle write/read of x5
        set_idle();
        wr_req = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        rd_addr = {5'd0, 5'd5};
        run_cycle();
        check("x5_bypass", rdata_r[31:0], 32'hDEADBEEF);
        set_idle();
        run_cycle();
        check("x5_comb_next", rdata_c[31:0], 32'hDEADBEEF);

        // Dual-port collision on x7
        wr_req = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22222222, 32'h11111111};
        rd_addr = {5'd7, 5'd7};
        run_cycle();
        check("x7_collide_byp", rdata_r[63:32], 32'h22222222);
        set_idle();
        run_cycle();

        // x0 stays zero and never busy
        wr_req = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
        rsv_req = 1'b1; rsv_addr = 5'd0; rd_addr = {5'd0, 5'd0};
        run_cycle();
        set_idle();
        run_cycle();

        // Scoreboard reserve/clear/flush
        rsv_req = 1'b1; rsv_addr = 5'd3; rd_addr = {5'd3, 5'd3};
        run_cycle();
        check("x3_rsv_busy", {31'b0, busy_r[0]}, 32'h1);
        set_idle();
        wr_req = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h33, 32'h0};
        run_cycle();
        check("x3_wr_busy", {31'b0, busy_r[0]}, 32'h0);
        set_idle();
        rsv_req = 1'b1; rsv_addr = 5'd4; wr_req = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h44};
        rd_addr = {5'd4, 5'd4};
        run_cycle();
        check("x4_rsv_wr_busy", {31'b0, busy_r[1]}, 32'h1);
        set_idle();
        rsv_req = 1'b1; rsv_addr = 5'd6; flush = 1'b1; rd_addr = {5'd4, 5'd6};
        run_cycle();
        check("x6_flush_busy", {30'b0, busy_r}, 32'h0);
        set_idle();
        rd_addr = {5'd4, 5'd3};
        run_cycle();

        // Return-value mirror
        wr_req = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h00000042};
        run_cycle();
        check("ret_x10", ret_r, 32'h42);
        set_idle();

        for (int n = 0; n < 60; n++) begin
            wr_req   = 2'($urandom_range(0, 3));
            wr_addr  = 10'($urandom_range(0, 1023));
            wr_data  = {$urandom, $urandom};
            rsv_req  = 1'($urandom_range(0, 1));
            rsv_addr = 5'($urandom_range(0, 31));
            flush    = ($urandom_range(0, 7) == 0);
            rd_addr  = 10'($urandom_range(0, 1023));
            run_cycle();
        end

        // Asynchronous reset between edges
        set_idle();
        wr_req = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'h00000042};
        rsv_req = 1'b1; rsv_addr = 5'd5; rd_addr = {5'd10, 5'd5};
        run_cycle();
        set_idle();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle();

        check("queues_drained", 32'(q_c.size() + q_r.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
